ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_tx.sv | 156 +++++++++++++++
 tb/tb_ps2_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional macro PS2_TX_TIMEOUT_EN adds a watchdog on device clock edges.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic       start,
  input  logic [7:0] din,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned MaxCycles =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
  localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    StIdle, StInhibit, StReq, StData, StParity, StStop, StAck, StWaitRel
  } state_e;

  state_e          r_state, w_state_d;
  logic [1:0]      r_clk_sync, r_data_sync;
  logic            r_clk_prev;
  logic [7:0]      r_shift, w_shift_d;
  logic            r_parity, w_parity_d;
  logic            r_tx_bit, w_tx_bit_d;
  logic [2:0]      r_bit_cnt, w_bit_cnt_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_ack, w_ack_d;

  logic            w_clk_s, w_data_s, w_fe;
  logic [CntW-1:0] w_cnt_inc;

  assign w_clk_s   = r_clk_sync[1];
  assign w_data_s  = r_data_sync[1];
  assign w_fe      = r_clk_prev & ~w_clk_s;
  assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + CntW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tx_bit    <= 1'b0;
      r_bit_cnt   <= '0;
      r_cnt       <= '0;
      r_ack       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_clk_sync  <= {r_clk_sync[0], ps2clk};
      r_data_sync <= {r_data_sync[0], ps2data};
      r_clk_prev  <= w_clk_s;
      r_shift     <= w_shift_d;
      r_parity    <= w_parity_d;
      r_tx_bit    <= w_tx_bit_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_cnt       <= w_cnt_d;
      r_ack       <= w_ack_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_parity_d  = r_parity;
    w_tx_bit_d  = r_tx_bit;
    w_bit_cnt_d = r_bit_cnt;
    w_cnt_d     = r_cnt;
    w_ack_d     = r_ack;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_shift_d   = din;
          w_parity_d  = ~^din;
          w_bit_cnt_d = '0;
          w_cnt_d     = '0;
          w_state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (r_cnt >= InhLast) begin
          w_cnt_d   = '0;
          w_state_d = StReq;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      StReq: begin
        if (w_fe) begin
          w_tx_bit_d  = r_shift[0];
          w_shift_d   = {1'b0, r_shift[7:1]};
          w_bit_cnt_d = '0;
          w_state_d   = StData;
        end
      end
      StData: begin
        if (w_fe) begin
          if (r_bit_cnt == 3'd7) begin
            w_tx_bit_d = r_parity;
            w_state_d  = StParity;
          end else begin
            w_tx_bit_d  = r_shift[0];
            w_shift_d   = {1'b0, r_shift[7:1]};
            w_bit_cnt_d = r_bit_cnt + 3'd1;
          end
        end
      end
      StParity: if (w_fe) w_state_d = StStop;
      StStop: begin
        if (w_fe) begin
          w_ack_d   = ~w_data_s;
          w_state_d = StAck;
        end
      end
      StAck:     if (w_clk_s && w_data_s) w_state_d = StWaitRel;
      StWaitRel: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog: any device-clocked state without an fe for TIMEOUT_CYCLES reports err.
    if (r_state inside {StReq, StData, StParity, StStop, StAck}) begin
      if (w_fe) begin
        w_cnt_d = '0;
      end else if (r_cnt >= ToLast && w_state_d != StWaitRel) begin
        w_ack_d   = 1'b0;
        w_state_d = StWaitRel;
      end else begin
        w_cnt_d = w_cnt_inc;
      end
    end
`endif
  end

  assign ps2clk_oe  = (r_state == StInhibit);
  assign ps2data_oe = (r_state == StReq) ||
                      (((r_state == StData) || (r_state == StParity)) && !r_tx_bit);
  assign busy       = (r_state != StIdle) && (r_state != StWaitRel);
  assign done       = (r_state == StWaitRel) && r_ack;
  assign err        = (r_state == StWaitRel) && !r_ack;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: behavioural PS/2 device model with randomized bytes.
module tb_ps2_tx;
  localparam int Inh = 40;
  localparam int To  = 400;
  localparam int H   = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2clk_pad, ps2data_pad;
  logic       ps2clk_oe, ps2data_oe, busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  assign ps2clk_pad  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_pad = ~(ps2data_oe | dev_data_low);

  ps2_tx #(.INHIBIT_CYCLES(Inh), .TIMEOUT_CYCLES(To)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2clk     (ps2clk_pad),
    .ps2data    (ps2data_pad),
    .start      (start),
    .din        (din),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (done === 1'b1 && err === 1'b1) both_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: full frame; 1: reset after fe cut_k; 2: device stops clocking after fe cut_k.
  task automatic send_frame(input logic [7:0] b, input bit do_ack, input int poke_k,
                            input int mode, input int cut_k);
    logic [10:0] expb, got;
    int ones, n, d0, e0;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    expb[0] = 1'b0;
    for (int i = 0; i < 8; i++) expb[i+1] = b[i];
    expb[9]  = (ones % 2 == 0);
    expb[10] = 1'b1;
    got = '0;
    d0 = done_cnt;
    e0 = err_cnt;

    din = b; start = 1'b1; tick(); start = 1'b0; din = 8'($urandom);
    check("busy_after_start", busy, 1);
    n = 0;
    while (ps2clk_oe === 1'b1 && n < 4 * Inh) begin n++; tick(); end
    check("inhibit_len", n, Inh);
    check("request_start_bit", ps2data_oe, 1);

    for (int k = 1; k <= 11; k++) begin
      repeat (H / 2) tick();
      got[k-1] = ps2data_pad;
      if (k == 11 && do_ack) dev_data_low = 1'b1;
      repeat (H - H / 2) tick();
      dev_clk_low = 1'b1;
      if (mode == 1 && k == cut_k) begin
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_clk_oe", ps2clk_oe, 0);
        check("rst_data_oe", ps2data_oe, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        dev_clk_low = 1'b0;
        repeat (4 * H) tick();
        check("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        return;
      end
      if (poke_k == k) begin
        din = 8'h00; start = 1'b1; tick(); start = 1'b0;
        repeat (H - 1) tick();
      end else begin
        repeat (H) tick();
      end
      dev_clk_low = 1'b0;
      if (mode == 2 && k == cut_k) begin
        n = H;
`ifdef PS2_TX_TIMEOUT_EN
        while (err !== 1'b1 && n < To + H + 50) begin tick(); n++; end
        check("timeout_err", err, 1);
        check("timeout_delay_ok", (n >= To && n <= To + 6), 1);
        check("timeout_rel_clk", ps2clk_oe, 0);
        check("timeout_rel_data", ps2data_oe, 0);
        tick();
        check("timeout_single_pulse", err, 0);
        check("timeout_no_done", done_cnt - d0, 0);
`else
        repeat (3 * To) tick();
        check("stall_no_err", err_cnt - e0, 0);
        check("stall_still_busy", busy, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
`endif
        return;
      end
    end

    n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < 8 * H) begin
      if (n == H / 2) dev_data_low = 1'b0;
      tick();
      n++;
    end
    dev_data_low = 1'b0;
    for (int j = 0; j < 11; j++)
      check($sformatf("frame_bit%0d_byte%02h", j, b), got[j], expb[j]);
    check("done_level", done, do_ack);
    check("err_level", err, !do_ack);
    check("busy_at_pulse", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("err_one_cycle", err, 0);
    check("idle_clk_oe", ps2clk_oe, 0);
    check("idle_data_oe", ps2data_oe, 0);
    check("pulse_count", (done_cnt - d0) + (err_cnt - e0), 1);
    check("done_count", done_cnt - d0, do_ack);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_clk_oe", ps2clk_oe, 0);
    check("reset_data_oe", ps2data_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    rst_n = 1'b1;
    tick();

    send_frame(8'hED, 1'b1, 0, 0, 0);
    send_frame(8'hFF, 1'b0, 0, 0, 0);
    send_frame(8'($urandom), 1'b1, 5, 0, 0);
    send_frame(8'h00, 1'b1, 0, 0, 0);
    for (int r = 0; r < 4; r++) send_frame(8'($urandom), 1'($urandom), 0, 0, 0);
    send_frame(8'($urandom), 1'b1, 0, 1, 4);
    send_frame(8'($urandom), 1'b1, 0, 0, 0);
    send_frame(8'($urandom), 1'b1, 0, 2, 4);
    send_frame(8'($urandom), 1'b0, 0, 0, 0);

    check("done_err_overlap", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
